// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath blocks: operand width,
// serial-counter width and the subtractor FSM state encoding.
package calc_pkg;

  localparam int CALC_WIDTH = 8;
  localparam int COUNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sub_state_t;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when a borrow
// propagates out. With bin tied low it behaves as a half subtractor.
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8.sv
// Bit-serial WIDTH-bit subtractor: D = A - B with borrow-out.
// Operands are captured on the start handshake and processed LSB-first,
// one bit per clock, through a single full_sub_bit cell and a registered
// borrow. The result is held with res_valid until res_ack.
// Optional build macro: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow
// output ovf, derived from the operand MSBs captured at acceptance.
module serial_subtractor_8
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             bit_d;
  logic             bit_bout;

  // Bit cell: current LSBs of the operand shift registers plus the running borrow.
  full_sub_bit u_bit (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (bw_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Next-state, datapath shifting and registered-output decode.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    count_d  = count_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          // Borrow cleared here so bit 0 is a plain half-subtract.
          sa_d    = a_in;
          sb_d    = b_in;
          sr_d    = '0;
          count_d = '0;
          bw_d    = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = a_in[WIDTH-1];
          b_msb_d = b_in[WIDTH-1];
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sr_d    = {bit_d, sr_q[WIDTH-1:1]};
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        bw_d    = bit_bout;
        if (count_q == LAST_BIT) begin
          // Final bit: publish the assembled result and the outgoing borrow.
          diff_d   = {bit_d, sr_q[WIDTH-1:1]};
          borrow_d = bit_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
`endif
          state_d  = DONE;
        end
      end

      DONE: begin
        // start is deliberately not looked at here; ack always wins.
        if (res_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT);
    valid_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      count_q  <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      count_q  <= count_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign res_valid  = valid_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_8.sv
// Self-checking bench for serial_subtractor_8: directed vectors, random
// operands against an arithmetic reference, ignored-input cases, the
// start+ack collision and reset in the middle of an operation.
module tb_serial_subtractor_8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       ready;
  logic       busy;
  logic       res_valid;
  logic       res_ack;
  logic [7:0] diff;
  logic       borrow_out;
  logic       ovf;

  int errors;
  int checks;

  // results of the most recent run_op
  logic [7:0] got_d;
  logic       got_bo;
  logic       got_ov;
  int         got_lat;
  // last completed result, expected to persist on the pins
  logic [7:0] last_d;
  logic       last_bo;

  serial_subtractor_8 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .ready      (ready),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ack    (res_ack),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] d, output logic bo,
                                output logic ov);
    int u;
    int s;
    u  = int'(a) - int'(b);
    s  = int'($signed(a)) - int'($signed(b));
    bo = (u < 0);
    d  = 8'((u + 256) % 256);
    ov = (s < -128) || (s > 127);
  endfunction

  // Waits for ready, issues one start, returns the result and its latency
  // in cycles after the accepting edge (-1 on timeout). Does not ack.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    int w;
    w = 0;
    while (!ready && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    got_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        got_lat = i;
        break;
      end
    end
    got_d  = diff;
    got_bo = borrow_out;
    got_ov = ovf;
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
    last_d  = got_d;
    last_bo = got_bo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
        diff !== 8'h00 || borrow_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b busy=%b valid=%b diff=%h bo=%b ovf=%b, want 1 0 0 00 0 0",
               ready, busy, res_valid, diff, borrow_out, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%b valid=%b, want 1 0", ready, res_valid);
    end
    last_d  = 8'h00;
    last_bo = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] av [6] = '{8'd100, 8'd5, 8'd0, 8'hAA, 8'h80, 8'h7F};
    logic [7:0] bv [6] = '{8'd37,  8'd9, 8'd1, 8'hAA, 8'h01, 8'hFF};
    logic [7:0] ed [6] = '{8'd63,  8'hFC, 8'hFF, 8'h00, 8'h7F, 8'h80};
    logic       eb [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      run_op(av[k], bv[k]);
      checks++;
      if (got_lat !== 8 || got_d !== ed[k] || got_bo !== eb[k]) begin
        errors++;
        $display("FAIL directed_%0d: lat=%0d diff=%h bo=%b, want lat=8 diff=%h bo=%b",
                 k, got_lat, got_d, got_bo, ed[k], eb[k]);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (got_ov !== eo[k]) begin
        errors++;
        $display("FAIL directed_ovf_%0d: ovf=%b want %b", k, got_ov, eo[k]);
      end
`endif
      // result must hold until acknowledged
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b1 || diff !== ed[k] || borrow_out !== eb[k] || ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b diff=%h bo=%b ready=%b, want 1 %h %b 0",
                 k, res_valid, diff, borrow_out, ready, ed[k], eb[k]);
      end
      do_ack();
      checks++;
      if (ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_ack_%0d: ready=%b valid=%b busy=%b, want 1 0 0",
                 k, ready, res_valid, busy);
      end
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(8'h10, 8'h01);
    checks++;
    if (got_ov !== 1'b0 || got_d !== 8'h0F) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b diff=%h, want 0 0f", got_ov, got_d);
    end
    do_ack();
`endif
  endtask

  task automatic test_random();
    logic [7:0] a, b, ed;
    logic       eb, eo;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (k == 0) begin a = 8'h00; b = 8'hFF; end
      if (k == 1) begin a = 8'hFF; b = 8'h00; end
      model(a, b, ed, eb, eo);
      run_op(a, b);
      checks++;
      if (got_lat !== 8 || got_d !== ed || got_bo !== eb) begin
        errors++;
        $display("FAIL random_%0d (%h-%h): lat=%0d diff=%h bo=%b, want lat=8 diff=%h bo=%b",
                 k, a, b, got_lat, got_d, got_bo, ed, eb);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++;
      if (got_ov !== eo) begin
        errors++;
        $display("FAIL random_ovf_%0d (%h-%h): ovf=%b want %b", k, a, b, got_ov, eo);
      end
`endif
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      do_ack();
    end
  endtask

  // start pulses and operand changes during SHIFT, start alone and start+ack in DONE
  task automatic test_ignore();
    logic [7:0] ed;
    logic       eb, eo;
    int         bad;
    model(8'd77, 8'd200, ed, eb, eo);
    start = 1'b1;
    a_in  = 8'd77;
    b_in  = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b1 || ready !== 1'b0 || res_valid !== 1'b0 ||
          diff !== last_d || borrow_out !== last_bo) bad++;
      if (i == 2) begin
        start = 1'b1;
        a_in  = 8'd3;
        b_in  = 8'd1;
      end
      if (i == 4) begin
        start = 1'b0;
        a_in  = 8'hFF;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL shift_status: %0d bad cycles (busy/ready/valid or stale result %h/%b)",
               bad, last_d, last_bo);
    end
    checks++;
    if (res_valid !== 1'b1 || diff !== ed || borrow_out !== eb) begin
      errors++;
      $display("FAIL ignore_result: valid=%b diff=%h bo=%b, want 1 %h %b",
               res_valid, diff, borrow_out, ed, eb);
    end
    // start alone in DONE
    start = 1'b1;
    a_in  = 8'd9;
    b_in  = 8'd2;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b0 || diff !== ed) begin
      errors++;
      $display("FAIL start_in_done: valid=%b busy=%b diff=%h, want 1 0 %h",
               res_valid, busy, diff, ed);
    end
    // start together with ack
    res_ack = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    res_ack = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_ack: ready=%b busy=%b valid=%b, want 1 0 0",
               ready, busy, res_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ack_no_op: ready=%b busy=%b, want 1 0", ready, busy);
    end
    last_d  = ed;
    last_bo = eb;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    a_in  = 8'd250;
    b_in  = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
        diff !== 8'h00 || borrow_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b busy=%b valid=%b diff=%h bo=%b ovf=%b, want 1 0 0 00 0 0",
               ready, busy, res_valid, diff, borrow_out, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL aborted_op: valid=%b ready=%b, want 0 1", res_valid, ready);
    end
    run_op(8'd200, 8'd55);
    checks++;
    if (got_lat !== 8 || got_d !== 8'd145 || got_bo !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d diff=%0d bo=%b, want 8 145 0",
               got_lat, got_d, got_bo);
    end
    do_ack();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    res_ack = 1'b0;
    a_in    = 8'h00;
    b_in    = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
